// File: rtl/mutative_sram_pkg.sv
// mutative_sram_pkg: controller state type and read-latency legality helpers
package mutative_sram_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam int MAX_READ_LATENCY = 2;
    function automatic bit latency_ok(input int l);
        return l >= 1 && l <= MAX_READ_LATENCY;
    endfunction
endpackage

// File: rtl/mutative_byte_merge.sv
// mutative_byte_merge: per-lane select between stored and incoming data
module mutative_byte_merge #(
    parameter int DATA_WIDTH = 256,
    parameter int WMASK_GRAN = 8
) (
    input  logic [DATA_WIDTH-1:0]            old_data,
    input  logic [DATA_WIDTH-1:0]            new_data,
    input  logic [DATA_WIDTH/WMASK_GRAN-1:0] mask,
    output logic [DATA_WIDTH-1:0]            merged
);
    for (genvar i = 0; i < DATA_WIDTH / WMASK_GRAN; i++) begin : g_lane
        assign merged[i*WMASK_GRAN +: WMASK_GRAN] = mask[i] ? new_data[i*WMASK_GRAN +: WMASK_GRAN]
                                                            : old_data[i*WMASK_GRAN +: WMASK_GRAN];
    end
endmodule

// File: rtl/mutative_sram_1r1w.sv
// mutative_sram_1r1w: 1R1W masked SRAM with write-first forwarding and a clear sweep
module mutative_sram_1r1w
    import mutative_sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 4,
    parameter int WMASK_GRAN   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk0,
    input  logic                             rst0,
    input  logic                             csb0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    output logic [DATA_WIDTH-1:0]            dout0,
    output logic                             rvalid0,
    input  logic                             csb1,
    input  logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask1,
    input  logic [DATA_WIDTH-1:0]            din1,
    input  logic                             clear_req,
    output logic                             busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LAT   = latency_ok(READ_LATENCY) ? READ_LATENCY : 1;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   sweep, sweep_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   wr_data, fwd_data, rd_data, s_data;
    logic                    rd, wr, s_valid;

    assign busy = state == CLEAR;
    assign rd   = !csb0 && !busy;
    assign wr   = !csb1 && !busy;

    always_comb begin
        state_next = busy ? (sweep == ADDR_WIDTH'(DEPTH - 1) ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
        sweep_next = busy ? sweep + 1'b1 : '0;
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= CLEAR;
            sweep <= '0;
        end else begin
            state <= state_next;
            sweep <= sweep_next;
        end
    end

    always_ff @(posedge clk0) begin
        if (busy) mem[sweep] <= '0;
        else if (wr) mem[addr1] <= wr_data;
    end

    mutative_byte_merge #(.DATA_WIDTH(DATA_WIDTH), .WMASK_GRAN(WMASK_GRAN)) u_wr_merge (
        .old_data(mem[addr1]), .new_data(din1), .mask(wmask1), .merged(wr_data)
    );
    mutative_byte_merge #(.DATA_WIDTH(DATA_WIDTH), .WMASK_GRAN(WMASK_GRAN)) u_fwd_merge (
        .old_data(mem[addr0]), .new_data(din1), .mask(wmask1), .merged(fwd_data)
    );

    // Same-cycle write to the read address is forwarded (write-first)
    assign rd_data = (wr && addr1 == addr0) ? fwd_data : mem[addr0];

    if (LAT == 2) begin : g_stage
        always_ff @(posedge clk0 or posedge rst0) begin
            if (rst0) begin
                s_valid <= 1'b0;
                s_data  <= '0;
            end else begin
                s_valid <= rd;
                s_data  <= rd_data;
            end
        end
    end else begin : g_direct
        assign s_valid = rd;
        assign s_data  = rd_data;
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rvalid0 <= 1'b0;
            dout0   <= '0;
        end else begin
            rvalid0 <= s_valid;
            if (s_valid) dout0 <= s_data;
        end
    end
endmodule

// File: tb/tb_mutative_sram_1r1w.sv
// tb_mutative_sram_1r1w: directed checks of a latency-1 and a latency-2 instance driven in parallel
module tb_mutative_sram_1r1w;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int NM = 32;

    logic          clk0 = 1'b0, rst0 = 1'b1, csb0 = 1'b1, csb1 = 1'b1, clear_req = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [NM-1:0] wmask1 = '0;
    logic [DW-1:0] din1 = '0, dout1, dout2;
    logic          rvalid1, rvalid2, busy1, busy2;
    int            checks = 0, errors = 0, n;

    always #5 clk0 = ~clk0;

    mutative_sram_1r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(8), .READ_LATENCY(1)) dut1 (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .addr0(addr0), .dout0(dout1), .rvalid0(rvalid1),
        .csb1(csb1), .addr1(addr1), .wmask1(wmask1), .din1(din1), .clear_req(clear_req), .busy(busy1)
    );
    mutative_sram_1r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(8), .READ_LATENCY(2)) dut2 (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .addr0(addr0), .dout0(dout2), .rvalid0(rvalid2),
        .csb1(csb1), .addr1(addr1), .wmask1(wmask1), .din1(din1), .clear_req(clear_req), .busy(busy2)
    );

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy1 && cnt < 40) begin
            step();
            cnt++;
            chk("busy_no_rvalid", rvalid1, 0);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_busy1", busy1, 1);
        chk("rst_rvalid2", rvalid2, 0);
        chk("rst_busy2", busy2, 1);
        rst0 = 1'b0;
        count_busy(n);
        chk("init_busy_len", n, 16);
        chk("init_busy2_low", busy2, 0);

        for (int a = 0; a < 16; a++) begin
            csb0 = 1'b0;
            addr0 = AW'(a);
            step();
            chk("zero_rvalid", rvalid1, 1);
            chk("zero_data", dout1, 0);
            if (a == 0) chk("lat2_not_yet", rvalid2, 0);
        end
        csb0 = 1'b1;
        step();
        chk("idle_rvalid", rvalid1, 0);

        csb1 = 1'b0; addr1 = 4'd3; din1 = {32{8'hAA}}; wmask1 = '1;
        step();
        din1 = {32{8'h55}}; wmask1 = 32'h0000_000F;
        step();
        csb1 = 1'b1; csb0 = 1'b0; addr0 = 4'd3;
        step();
        chk("mask_rvalid", rvalid1, 1);
        chk("mask_data", dout1, {{28{8'hAA}}, {4{8'h55}}});
        csb0 = 1'b1;
        step();
        chk("hold_rvalid", rvalid1, 0);
        chk("hold_data", dout1, {{28{8'hAA}}, {4{8'h55}}});
        chk("lat2_mask_rvalid", rvalid2, 1);
        chk("lat2_mask_data", dout2, {{28{8'hAA}}, {4{8'h55}}});

        csb1 = 1'b0; addr1 = 4'd6; din1 = {32{8'h77}}; wmask1 = '1;
        csb0 = 1'b0; addr0 = 4'd3;
        step();
        chk("indep_read", dout1, {{28{8'hAA}}, {4{8'h55}}});
        csb1 = 1'b1; addr0 = 4'd6;
        step();
        chk("indep_write", dout1, {32{8'h77}});

        csb1 = 1'b0; addr1 = 4'd5; din1 = {32{8'h11}}; wmask1 = 32'h0000_00FF;
        csb0 = 1'b0; addr0 = 4'd5;
        step();
        chk("wf_rvalid", rvalid1, 1);
        chk("wf_data", dout1, {{24{8'h00}}, {8{8'h11}}});
        csb0 = 1'b1; csb1 = 1'b1;
        step();
        chk("lat2_wf_rvalid", rvalid2, 1);
        chk("lat2_wf_data", dout2, {{24{8'h00}}, {8{8'h11}}});

        for (int k = 0; k < 3; k++) begin
            csb1 = 1'b0; addr1 = AW'(k); din1 = {32{8'(k + 1)}}; wmask1 = '1;
            step();
        end
        csb1 = 1'b1;
        csb0 = 1'b0; addr0 = 4'd0;
        step();
        chk("lat2_first_gap", rvalid2, 0);
        addr0 = 4'd1;
        step();
        chk("lat2_v0", rvalid2, 1);
        chk("lat2_d0", dout2, {32{8'h01}});
        addr0 = 4'd2;
        step();
        chk("lat2_v1", rvalid2, 1);
        chk("lat2_d1", dout2, {32{8'h02}});
        csb0 = 1'b1;
        step();
        chk("lat2_v2", rvalid2, 1);
        chk("lat2_d2", dout2, {32{8'h03}});
        step();
        chk("lat2_after", rvalid2, 0);
        chk("lat2_hold", dout2, {32{8'h03}});

        csb1 = 1'b0; addr1 = 4'd7; din1 = '1; wmask1 = '1;
        step();
        csb1 = 1'b1; csb0 = 1'b0; addr0 = 4'd7; clear_req = 1'b1;
        step();
        chk("clr_read_rvalid", rvalid1, 1);
        chk("clr_read_data", dout1, '1);
        chk("clr_busy", busy1, 1);
        csb1 = 1'b0; addr1 = 4'd8; din1 = '1; wmask1 = '1;
        step();
        clear_req = 1'b0;
        chk("clr_inflight_v", rvalid2, 1);
        chk("clr_inflight_d", dout2, '1);
        chk("clr_no_rvalid", rvalid1, 0);
        count_busy(n);
        csb0 = 1'b1; csb1 = 1'b1;
        chk("clr_busy_len", n + 1, 16);
        csb0 = 1'b0; addr0 = 4'd7;
        step();
        chk("clr_a7_rvalid", rvalid1, 1);
        chk("clr_a7_zero", dout1, 0);
        addr0 = 4'd8;
        step();
        chk("clr_a8_zero", dout1, 0);
        csb0 = 1'b1;

        csb1 = 1'b0; addr1 = 4'd6; din1 = {32{8'h77}}; wmask1 = '1;
        step();
        csb1 = 1'b1; csb0 = 1'b0; addr0 = 4'd6; clear_req = 1'b1;
        step();
        csb0 = 1'b1; clear_req = 1'b0;
        chk("rstA_pre_data", dout1, {32{8'h77}});
        rst0 = 1'b1;
        #1;
        chk("rstA_rvalid1", rvalid1, 0);
        chk("rstA_dout1", dout1, 0);
        chk("rstA_busy", busy1, 1);
        rst0 = 1'b0;
        step();
        chk("rstA_discard", rvalid2, 0);
        repeat (8) step();
        chk("rstB_pre_busy", busy1, 1);
        rst0 = 1'b1;
        #1;
        chk("rstB_rvalid1", rvalid1, 0);
        chk("rstB_rvalid2", rvalid2, 0);
        rst0 = 1'b0;
        count_busy(n);
        chk("rstB_busy_len", n, 16);
        csb0 = 1'b0; addr0 = 4'd6;
        step();
        chk("rstB_a6_zero", dout1, 0);
        chk("rstB_a6_rvalid", rvalid1, 1);
        csb0 = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
